seq_divider: RTL
================

# seq_divider

Iterative restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits beside the single-cycle lookahead adder in the execute stage and handles the inverse operation: repeated shift-and-subtract, one quotient bit per clock. The issue logic uses a start/busy/done handshake with it.

## Interface
- XLEN, 32: operand and result width. Must be ≥ 4.
- clk  input  1  clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- start  input  1  request; accepted only in IDLE or DONE.
- op  input  2  operation, sampled with start: 0 DIV, 1 DIVU, 2 REM, 3 REMU.
- dividend  input  XLEN  rs1, sampled with start.
- divisor  input  XLEN  rs2, sampled with start.
- busy  output  1  high while in CALC or FIX; reset 0.
- done  output  1  one-cycle pulse when result is valid; reset 0.
- result  output  XLEN  quotient (op 0/1) or remainder (op 2/3). Held until the next accepted start. Reset 0.

## Operation
- States and transitions:
  - IDLE → CALC on start.
  - CALC → FIX after XLEN iterations.
  - FIX → DONE.
  - DONE → CALC if start is high; otherwise DONE → IDLE.
- On accept, the block latches op and takes magnitudes of the operands:
  - Signed ops (0/2): two's-complement absolute value of each operand.
  - Unsigned ops: operands used as-is.
- Signs are recorded for the fix step:
  - Quotient sign = sign(dividend) XOR sign(divisor).
  - Remainder sign = sign(dividend).
- Each CALC cycle:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem − divisor_mag as an (XLEN+1)-bit subtraction.
  - If trial ≥ 0: rem = trial, quo[0] = 1. Otherwise restore rem and set quo[0] = 0.
  - A 6-bit iteration counter counts 0..XLEN−1.
- FIX: apply the recorded signs to quo and rem, select by op, and register the value into result.
- Special cases, resolved in FIX and overriding the iterative result:
  - Divisor = 0: quotient = all ones; remainder = dividend (original, unsigned view).
  - Signed overflow (dividend = 2^(XLEN−1), divisor = all ones, op 0/2): quotient = dividend; remainder = 0.
- start while busy is ignored. It does not queue, and operands are not resampled.
- Reset asserted at any time returns the block to IDLE and clears busy, done and result. No done is issued for an aborted operation.

## Timing
- Cycle 0: start high, accepted.
- Cycles 1..XLEN: CALC.
- Cycle XLEN+1: FIX.
- Cycle XLEN+2: DONE; done = 1, result valid, busy = 0.
- Latency from start to done is XLEN+2 cycles (34 for XLEN = 32).
- busy is high in cycles 1..XLEN+1.
- Back-to-back throughput: start accepted in the DONE cycle begins CALC in the next cycle, giving one result every XLEN+2 cycles.
- result changes only on the FIX→DONE edge (or on the early-out edge, see Configuration). It is stable at all other times.

## Configuration
- DIV_EARLY_OUT_EN:
  - Defined: when divide-by-zero or signed overflow is detected at accept, the FSM goes IDLE/DONE → DONE directly. result is loaded on that edge, done is in cycle 1, and busy stays 0.
  - Undefined: special cases take the full XLEN+2 latency with identical result values.

## Test plan
- DIVU 100 / 7 at cycle 0 → busy cycles 1..33; done only in cycle 34; result = 14. Repeat with REMU → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3). REM same operands → 0xFFFFFFFF (−1). REM 7 / 0xFFFFFFFE → 1.
- DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0. Run with and without DIV_EARLY_OUT_EN: with the macro, done is in cycle 1; without it, done is in cycle 34.
- Pulse start with new operands during cycle 10 of an operation → ignored; the original result is delivered in cycle 34. Start in the DONE cycle → second done exactly 34 cycles later.
- Assert rstn low during cycle 20 → busy, done and result go to 0 asynchronously. No done follows. The next start after reset release completes normally.
- Random signed/unsigned sweep of 10k operand pairs checked against a reference model → every result matches, and exactly one done per accepted start.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Latency: start to done is XLEN+2 cycles (1 cycle for special cases when DIV_EARLY_OUT_EN is defined).
// Backpressure: start is accepted only in IDLE or DONE; start while busy is ignored (no queueing).
//
// Ports:
//   clk, rstn           clock (rising edge), asynchronous active-low reset
//   start, op           request and operation (0 DIV, 1 DIVU, 2 REM, 3 REMU), sampled on accept
//   dividend, divisor   rs1 / rs2, sampled on accept
//   busy                high while in CALC or FIX
//   done                one-cycle pulse when result is valid
//   result              quotient (op 0/1) or remainder (op 2/3), held until the next accepted start
//
// Optional feature macro: DIV_EARLY_OUT_EN -- divide-by-zero and signed overflow skip CALC/FIX
// and complete in the cycle after accept.

module seq_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT_EN = 1'b1;
`else
  localparam bit EARLY_OUT_EN = 1'b0;
`endif

  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0]      LAST_ITER  = 6'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] dvd_q;     // original dividend, needed for the divide-by-zero remainder
  logic [XLEN-1:0] div_mag;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;       // holds the dividend magnitude at first, shifted out as quotient bits come in
  logic            q_neg;
  logic            r_neg;
  logic            div_zero;
  logic            ovf;
  logic [5:0]      cnt;

  // Accept-time decode of the incoming operands.
  logic            accept;
  logic            is_signed;
  logic            in_zero;
  logic            in_ovf;
  logic [XLEN-1:0] dvd_abs;
  logic [XLEN-1:0] dsr_abs;
  logic [XLEN-1:0] early_val;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign is_signed = ~op[0];
  assign in_zero   = (divisor == '0);
  assign in_ovf    = is_signed && (dividend == SIGNED_MIN) && (&divisor);
  assign dvd_abs   = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
  assign dsr_abs   = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;

  // Special-case result straight from the inputs (early-out path only).
  always_comb begin
    early_val = '0;
    if (in_zero) early_val = op[1] ? dividend : '1;
    else         early_val = op[1] ? '0 : dividend;
  end

  // One restoring step: bring the next dividend bit into the partial remainder and
  // try to subtract. The extra top bit of trial is the borrow (negative result).
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  assign rem_sh = {rem, quo[XLEN-1]};
  assign trial  = rem_sh - {1'b0, div_mag};

  // Sign fix-up and final selection; special cases override the iterative result.
  logic [XLEN-1:0] quo_s;
  logic [XLEN-1:0] rem_s;
  logic [XLEN-1:0] fix_val;

  always_comb begin
    quo_s   = q_neg ? -quo : quo;
    rem_s   = r_neg ? -rem : rem;
    fix_val = op_q[1] ? rem_s : quo_s;
    if (div_zero)  fix_val = op_q[1] ? dvd_q : '1;
    else if (ovf)  fix_val = op_q[1] ? '0 : dvd_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      op_q     <= '0;
      dvd_q    <= '0;
      div_mag  <= '0;
      rem      <= '0;
      quo      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept) begin
            op_q     <= op;
            dvd_q    <= dividend;
            div_mag  <= dsr_abs;
            rem      <= '0;
            quo      <= dvd_abs;
            q_neg    <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            r_neg    <= is_signed && dividend[XLEN-1];
            div_zero <= in_zero;
            ovf      <= in_ovf;
            cnt      <= '0;
            if (EARLY_OUT_EN && (in_zero || in_ovf)) begin
              state  <= DONE;
              result <= early_val;
              done   <= 1'b1;
            end else begin
              state  <= CALC;
              busy   <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end

        CALC: begin
          quo <= {quo[XLEN-2:0], ~trial[XLEN]};
          rem <= trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
          cnt <= cnt + 6'd1;
          if (cnt == LAST_ITER) state <= FIX;
        end

        FIX: begin
          result <= fix_val;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
